// File: rtl/nibbler_pc_sequencer_if.sv
// Bus between the Nibbler decoder/fetch stage and the PC sequencer.
// The master drives jump/halt/run controls; the slave (the sequencer)
// returns the ROM address, phase, status and retired-instruction count.
interface nibbler_pc_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic              halt_req;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              phase_out;
  logic              halted;
  logic              wrap_pulse;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output load_en, load_addr, halt_req, run,
    input  pc, phase_out, halted, wrap_pulse, instr_count
  );

  modport slave (
    input  load_en, load_addr, halt_req, run,
    output pc, phase_out, halted, wrap_pulse, instr_count
  );
endinterface

// File: rtl/nibbler_pc_sequencer.sv
// Nibbler fetch-stage sequencer: owns the program counter and the two-phase
// FETCH/EXEC timing, handles jumps and halt/run, and counts retired
// instructions. Every output is a register updated in the single FSM block.
module nibbler_pc_sequencer #(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  nibbler_pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              phase_reg;
  logic              halted_reg;
  logic              wrap_reg;
  logic [CNT_W-1:0]  count_reg;

  // Sequencer FSM: pc advances on the FETCH edge (the byte at pc is being
  // latched by the fetch register at that same edge), jumps and halts are
  // taken on the EXEC edge, and HALTED only waits for run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_VECTOR;
      phase_reg  <= 1'b0;
      halted_reg <= 1'b0;
      wrap_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          // Incrementing past the top address is the only source of a wrap;
          // a jump to address 0 deliberately does not count.
          wrap_reg   <= (pc_reg == {ADDR_W{1'b1}});
          pc_reg     <= pc_reg + 1'b1;
          state_reg  <= EXEC;
          phase_reg  <= 1'b1;
          halted_reg <= 1'b0;
        end
        EXEC: begin
          wrap_reg  <= 1'b0;
          count_reg <= count_reg + 1'b1;
          // Jump target lands directly in the next FETCH (no bubble);
          // otherwise pc already points past the fetched byte.
          if (bus.load_en) begin
            pc_reg <= bus.load_addr;
          end
          if (bus.halt_req) begin
            state_reg  <= HALTED;
            phase_reg  <= 1'b1;
            halted_reg <= 1'b1;
          end else begin
            state_reg  <= FETCH;
            phase_reg  <= 1'b0;
            halted_reg <= 1'b0;
          end
        end
        HALTED: begin
          wrap_reg <= 1'b0;
          if (bus.run) begin
            state_reg  <= FETCH;
            phase_reg  <= 1'b0;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= FETCH;
          phase_reg  <= 1'b0;
          halted_reg <= 1'b0;
          wrap_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.phase_out   = phase_reg;
  assign bus.halted      = halted_reg;
  assign bus.wrap_pulse  = wrap_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_nibbler_pc_sequencer.sv
// Self-checking bench for nibbler_pc_sequencer: directed scenarios followed by
// randomized control traffic, all compared each cycle against a behavioural
// model of the FETCH/EXEC/HALTED rules.
module tb_nibbler_pc_sequencer;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;
  localparam int PC_MOD = 1 << ADDR_W;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk;
  logic reset;

  nibbler_pc_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  nibbler_pc_sequencer #(
    .ADDR_W(ADDR_W),
    .RESET_VECTOR(12'h000),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: where the machine is ("fetch", "exec", "halted"), plus pc,
  // retired count and whether the last step was a wrap.
  string m_mode;
  int    m_pc;
  int    m_cnt;
  bit    m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     32'(bus.pc),          32'(m_pc));
    chk({tag, ".phase"},  32'(bus.phase_out),   32'(m_mode != "fetch"));
    chk({tag, ".halted"}, 32'(bus.halted),      32'(m_mode == "halted"));
    chk({tag, ".wrap"},   32'(bus.wrap_pulse),  32'(m_wrap));
    chk({tag, ".count"},  32'(bus.instr_count), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_mode = "fetch";
    m_pc   = 0;
    m_cnt  = 0;
    m_wrap = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // then let the DUT take the edge and compare shortly after it.
  task automatic tick(input string tag);
    if (m_mode == "fetch") begin
      m_wrap = (m_pc == PC_MOD - 1);
      m_pc   = (m_pc + 1) % PC_MOD;
      m_mode = "exec";
    end else if (m_mode == "exec") begin
      m_wrap = 1'b0;
      m_cnt  = (m_cnt + 1) % CNT_MOD;
      if (bus.load_en) m_pc = int'(bus.load_addr);
      m_mode = bus.halt_req ? "halted" : "fetch";
    end else begin
      m_wrap = 1'b0;
      if (bus.run) m_mode = "fetch";
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.halt_req  = 1'b0;
    bus.run       = 1'b0;
  endtask

  task automatic to_exec();
    idle_inputs();
    if (m_mode == "halted") begin
      bus.run = 1'b1;
      tick("resume");
      bus.run = 1'b0;
    end
    if (m_mode == "fetch") tick("to_exec");
  endtask

  initial begin
    int sel;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #12;
    check_all("reset");
    reset = 1'b0;

    // 1: free run, six edges
    for (int i = 0; i < 6; i++) tick("freerun");

    // 2: jump from EXEC, load_en held during FETCH is ignored
    to_exec();
    bus.load_en = 1'b1; bus.load_addr = 12'hA5C;
    tick("jump");
    chk("jump.pc_direct", 32'(bus.pc), 32'h0A5C);
    bus.load_addr = 12'h111;
    tick("jump_fetch_ignored");
    chk("jump.next_pc", 32'(bus.pc), 32'h0A5D);
    idle_inputs();

    // 3: wrap via increment from 0xFFF; a jump to 0 is not a wrap
    bus.load_en = 1'b1; bus.load_addr = 12'hFFF;
    tick("to_fff");
    idle_inputs();
    tick("wrap");
    chk("wrap.pulse", 32'(bus.wrap_pulse), 32'd1);
    tick("wrap_end");
    chk("wrap.one_cycle", 32'(bus.wrap_pulse), 32'd0);
    tick("to_exec2");
    bus.load_en = 1'b1; bus.load_addr = 12'h000;
    tick("jump_zero");
    chk("jump_zero.nowrap", 32'(bus.wrap_pulse), 32'd0);
    idle_inputs();

    // 4: halt with simultaneous jump, held 10 clocks under noise, then run
    to_exec();
    bus.halt_req = 1'b1; bus.load_en = 1'b1; bus.load_addr = 12'h300;
    tick("halt");
    chk("halt.pc", 32'(bus.pc), 32'h0300);
    for (int i = 0; i < 10; i++) begin
      bus.halt_req  = 1'($urandom_range(0, 1));
      bus.load_en   = 1'($urandom_range(0, 1));
      bus.load_addr = 12'($urandom);
      bus.run       = 1'b0;
      tick("halted_hold");
    end
    idle_inputs();
    bus.run = 1'b1;
    tick("run");
    chk("run.pc", 32'(bus.pc), 32'h0300);
    idle_inputs();

    // 5: run outside HALTED and halt_req during FETCH are ignored
    bus.run = 1'b1;
    tick("run_in_fetch");
    tick("run_in_exec");
    bus.run = 1'b0;
    bus.halt_req = 1'b1;
    tick("halt_in_fetch");
    chk("halt_in_fetch.not_halted", 32'(bus.halted), 32'd0);
    idle_inputs();
    tick("after_halt_in_fetch");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.load_en  = ($urandom_range(0, 2) == 0);
      bus.halt_req = ($urandom_range(0, 5) == 0);
      bus.run      = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: bus.load_addr = 12'hFFF;
        1: bus.load_addr = 12'hFFE;
        2: bus.load_addr = 12'h000;
        default: bus.load_addr = 12'($urandom);
      endcase
      tick("random");
    end

    // 6: asynchronous reset in the middle of an EXEC with a pending jump/halt
    to_exec();
    bus.load_en = 1'b1; bus.load_addr = 12'h123; bus.halt_req = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #3;
    reset = 1'b0;
    idle_inputs();
    #1;
    check_all("post_release");
    tick("first_fetch_edge");
    chk("first_fetch.pc", 32'(bus.pc), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
